// File: rtl/reg_file_wb_if.sv
// Register-file bus: read addresses, writeback sources and controls, and
// the read data / ready returned by the register file.
//   RF_ADR1/RF_ADR2 : read addresses (rs1/rs2)
//   RF_WA/RF_WE     : write address (rd) and write enable
//   RF_WR_SEL       : writeback source select
//   PC_PLUS4/CSR_RD/MEM_DOUT/ALU_RESULT : writeback sources 0..3
//   RF_RS1/RF_RS2   : read data, RF_READY : file usable
// master = the pipeline driving the file, slave = the register file.
interface reg_file_wb_if;
    logic [4:0]  RF_ADR1;
    logic [4:0]  RF_ADR2;
    logic [4:0]  RF_WA;
    logic        RF_WE;
    logic [1:0]  RF_WR_SEL;
    logic [31:0] PC_PLUS4;
    logic [31:0] CSR_RD;
    logic [31:0] MEM_DOUT;
    logic [31:0] ALU_RESULT;
    logic [31:0] RF_RS1;
    logic [31:0] RF_RS2;
    logic        RF_READY;

    modport master (
        output RF_ADR1, RF_ADR2, RF_WA, RF_WE, RF_WR_SEL,
               PC_PLUS4, CSR_RD, MEM_DOUT, ALU_RESULT,
        input  RF_RS1, RF_RS2, RF_READY
    );

    modport slave (
        input  RF_ADR1, RF_ADR2, RF_WA, RF_WE, RF_WR_SEL,
               PC_PLUS4, CSR_RD, MEM_DOUT, ALU_RESULT,
        output RF_RS1, RF_RS2, RF_READY
    );
endinterface

// File: rtl/reg_file_wb.sv
// 32 x 32-bit register file with writeback source mux, write-through
// bypass and an optional post-reset sequential clear.
//   CLK : rising-edge clock
//   RST : synchronous active-high reset
//   bus : reg_file_wb_if.slave (addresses, writeback sources, read data,
//         RF_READY)
// CLEAR_ON_RESET = 1 zeroes x0..x31 one per cycle after reset, RF_READY
// rising on the 32nd edge; 0 keeps contents and is ready at once.
module reg_file_wb #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic          CLK,
    input logic          RST,
    reg_file_wb_if.slave bus
);
    typedef enum logic {CLEAR, READY} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        ready;
    logic [31:0] regs [32];
    logic [31:0] wd;
    logic        wr_en;
    logic [31:0] rs1;
    logic [31:0] rs2;

    always_comb begin
        wd = '0;
        case (bus.RF_WR_SEL)
            2'd0:    wd = bus.PC_PLUS4;
            2'd1:    wd = bus.CSR_RD;
            2'd2:    wd = bus.MEM_DOUT;
            default: wd = bus.ALU_RESULT;
        endcase
    end

    // Qualified write; also the bypass condition, so reads never see a
    // write that the edge will not commit.
    assign wr_en = !RST && ready && bus.RF_WE && (bus.RF_WA != 5'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            if (CLEAR_ON_RESET) begin
                state <= CLEAR;
                cnt   <= '0;
                ready <= 1'b0;
            end else begin
                state <= READY;
                ready <= 1'b1;
            end
        end else begin
            case (state)
                CLEAR: begin
                    regs[cnt] <= '0;
                    cnt       <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    if (wr_en)
                        regs[bus.RF_WA] <= wd;
                end
            endcase
        end
    end

    always_comb begin
        rs1 = '0;
        rs2 = '0;
        if (ready) begin
            if (bus.RF_ADR1 != 5'd0)
                rs1 = (wr_en && bus.RF_WA == bus.RF_ADR1) ? wd : regs[bus.RF_ADR1];
            if (bus.RF_ADR2 != 5'd0)
                rs2 = (wr_en && bus.RF_WA == bus.RF_ADR2) ? wd : regs[bus.RF_ADR2];
        end
    end

    assign bus.RF_RS1   = rs1;
    assign bus.RF_RS2   = rs2;
    assign bus.RF_READY = ready;
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: one instance with CLEAR_ON_RESET=1
// and one with CLEAR_ON_RESET=0 share the same stimulus. The driver
// applies inputs just after each rising edge and pushes the expected
// outputs computed by an array-based model; a monitor pops and compares
// on each falling edge.
module tb_reg_file_wb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_wb_if bus0 ();
    reg_file_wb_if bus1 ();

    reg_file_wb #(.CLEAR_ON_RESET(1'b1)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    reg_file_wb #(.CLEAR_ON_RESET(1'b0)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          ready;
        bit          k1;
        bit          k2;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    // Model: contents per instance, whether each entry is known, ready
    // flag and edges since the last reset.
    logic [31:0] mem   [2][32];
    bit          known [2][32];
    bit          mrdy  [2];
    int unsigned since;
    bit          armed = 1'b0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", name, inst, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            popped++;
            check("ready", 0, {31'd0, bus0.RF_READY}, {31'd0, e.ready});
            if (e.k1) check("rs1", 0, bus0.RF_RS1, e.rs1);
            if (e.k2) check("rs2", 0, bus0.RF_RS2, e.rs2);
        end
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            popped++;
            check("ready", 1, {31'd0, bus1.RF_READY}, {31'd0, e.ready});
            if (e.k1) check("rs1", 1, bus1.RF_RS1, e.rs1);
            if (e.k2) check("rs2", 1, bus1.RF_RS2, e.rs2);
        end
    end

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] pc,
                                         input logic [31:0] csr, input logic [31:0] md,
                                         input logic [31:0] alu);
        logic [31:0] src [4];
        src[0] = pc; src[1] = csr; src[2] = md; src[3] = alu;
        return src[sel];
    endfunction

    task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] wa, input logic we, input logic [1:0] sel,
                       input logic [31:0] pc, input logic [31:0] csr,
                       input logic [31:0] md, input logic [31:0] alu);
        logic [31:0] wd;
        @(posedge clk);
        #1;
        rst = r;
        bus0.RF_ADR1 = a1;  bus1.RF_ADR1 = a1;
        bus0.RF_ADR2 = a2;  bus1.RF_ADR2 = a2;
        bus0.RF_WA = wa;    bus1.RF_WA = wa;
        bus0.RF_WE = we;    bus1.RF_WE = we;
        bus0.RF_WR_SEL = sel;  bus1.RF_WR_SEL = sel;
        bus0.PC_PLUS4 = pc;    bus1.PC_PLUS4 = pc;
        bus0.CSR_RD = csr;     bus1.CSR_RD = csr;
        bus0.MEM_DOUT = md;    bus1.MEM_DOUT = md;
        bus0.ALU_RESULT = alu; bus1.ALU_RESULT = alu;
        wd = pick(sel, pc, csr, md, alu);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            bit   qual;
            qual = !r && mrdy[i] && we && (wa != 5'd0);
            e.ready = mrdy[i];
            e.k1 = 1'b1;
            e.k2 = 1'b1;
            if (!mrdy[i] || a1 == 5'd0) e.rs1 = '0;
            else if (qual && wa == a1) e.rs1 = wd;
            else begin e.rs1 = mem[i][a1]; e.k1 = known[i][a1]; end
            if (!mrdy[i] || a2 == 5'd0) e.rs2 = '0;
            else if (qual && wa == a2) e.rs2 = wd;
            else begin e.rs2 = mem[i][a2]; e.k2 = known[i][a2]; end
            if (armed) begin
                if (i == 0) q0.push_back(e); else q1.push_back(e);
                pushed++;
            end
            // Effect of the coming edge.
            if (r) begin
                if (i == 0) begin
                    mrdy[0] = 1'b0;
                    since = 0;
                    for (int unsigned k = 0; k < 32; k++) begin
                        mem[0][k] = '0;
                        known[0][k] = 1'b1;
                    end
                end else begin
                    mrdy[1] = 1'b1;
                end
            end else begin
                if (qual) begin
                    mem[i][wa] = wd;
                    known[i][wa] = 1'b1;
                end
                if (i == 0 && !mrdy[0]) begin
                    since++;
                    if (since == 32) mrdy[0] = 1'b1;
                end
            end
        end
        if (r) armed = 1'b1;
    endtask

    task automatic idle(input int n, input logic [4:0] a1, input logic [4:0] a2);
        for (int k = 0; k < n; k++)
            cyc(1'b0, a1, a2, 5'd0, 1'b0, 2'd0, '0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mrdy[i] = 1'b0;
            for (int unsigned k = 0; k < 32; k++) begin
                mem[i][k] = '0;
                known[i][k] = 1'b0;
            end
        end
        since = 0;

        // Reset, then watch the clear sequence to ready.
        cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 2'd0, '0, '0, '0, '0);
        // Write to x3 while clearing must be lost.
        cyc(1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 2'd3, '0, '0, '0, 32'hA5A5A5A5);
        idle(34, 5'd3, 5'd0);
        // All addresses read zero on the clearing instance.
        for (int unsigned a = 0; a < 32; a++)
            cyc(1'b0, 5'(a), 5'(31 - a), 5'd0, 1'b0, 2'd0, '0, '0, '0, '0);

        // Writeback select.
        cyc(1'b0, 5'd5, 5'd6, 5'd5, 1'b1, 2'd3, '0, '0, '0, 32'hDEADBEEF);
        cyc(1'b0, 5'd5, 5'd6, 5'd6, 1'b1, 2'd0, 32'h00000104, '0, '0, '0);
        cyc(1'b0, 5'd8, 5'd9, 5'd8, 1'b1, 2'd1, '0, 32'h0C5A0001, '0, '0);
        cyc(1'b0, 5'd9, 5'd8, 5'd9, 1'b1, 2'd2, '0, '0, 32'h3E3D0002, '0);
        idle(1, 5'd5, 5'd6);
        idle(1, 5'd8, 5'd9);

        // x0 protection.
        idle(1, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'd3, '0, '0, '0, 32'hFFFFFFFF);
        idle(1, 5'd0, 5'd0);

        // Bypass on both ports.
        cyc(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 2'd3, '0, '0, '0, 32'h11111111);
        cyc(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 2'd3, '0, '0, '0, 32'h22222222);
        idle(1, 5'd7, 5'd7);

        // Reset in ready, then reset again at edge 10 of the clear.
        cyc(1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 2'd3, '0, '0, '0, 32'h99999999);
        idle(9, 5'd5, 5'd7);
        cyc(1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 2'd0, '0, '0, '0, '0);
        idle(33, 5'd5, 5'd7);

        // Random traffic with rare resets.
        for (int n = 0; n < 600; n++) begin
            logic r;
            r = ($urandom_range(0, 199) == 0);
            cyc(r, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
        end
        idle(40, 5'd1, 5'd2);

        for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++)
            @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain popped %0d want %0d", popped, pushed);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 The block SHALL have one parameter: CLEAR_ON_RESET, default 1, 1 = sequentially zero all 32 registers after reset, 0 = retain contents and go ready immediately.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named CLK and RST.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 RF_ADR1  in  5  read address, port 1 (rs1).
REQ-006 RF_ADR2  in  5  read address, port 2 (rs2).
REQ-007 RF_WA  in  5  write address (rd).
REQ-008 RF_WE  in  1  write enable.
REQ-009 RF_WR_SEL  in  2  writeback source select.
REQ-010 PC_PLUS4  in  32  writeback source 0.
REQ-011 CSR_RD  in  32  writeback source 1.
REQ-012 MEM_DOUT  in  32  writeback source 2.
REQ-013 ALU_RESULT  in  32  writeback source 3, the ALU output.
REQ-014 RF_RS1  out  32  port-1 read data, drives the ALU A-operand path.
REQ-015 RF_RS2  out  32  port-2 read data, drives the ALU B-operand path.
REQ-016 RF_READY  out  1  high when the file accepts writes and returns valid reads.

Function
REQ-017 Write data WD SHALL be combinational: sel 0 -> PC_PLUS4, 1 -> CSR_RD, 2 -> MEM_DOUT, 3 -> ALU_RESULT.
REQ-018 Storage SHALL be 32 x 32-bit registers, x0 through x31.
REQ-019 Writes SHALL occur on the rising CLK edge only when RST=0, RF_READY=1, RF_WE=1 and RF_WA!=0.
REQ-020 Writes to x0 SHALL be discarded, and reads of address 0 SHALL return 0 under all conditions.
REQ-021 Reads SHALL be combinational, with zero latency from address change to RF_RSn.
REQ-022 Write-through bypass: when a qualified write (REQ-019) targets RF_ADRn in the same cycle, RF_RSn SHALL return WD, not the stored value.
REQ-023 If both read ports address the same register, both SHALL return identical data, including bypass.
REQ-024 The FSM SHALL have two states, CLEAR and READY; a 5-bit clear counter CNT SHALL be present.
REQ-025 On an edge with RST=1 and CLEAR_ON_RESET=1: state <= CLEAR, CNT <= 0, RF_READY <= 0.
REQ-026 On an edge with RST=1 and CLEAR_ON_RESET=0: state <= READY, RF_READY <= 1, register contents unchanged.
REQ-027 In CLEAR on each edge with RST=0: register[CNT] <= 0 and CNT <= CNT+1; when CNT==31, state <= READY and RF_READY <= 1 on that edge.
REQ-028 RF_READY SHALL therefore rise on the 32nd edge after the last reset edge.
REQ-029 In CLEAR, RF_WE SHALL be ignored, no bypass SHALL apply, and RF_RS1/RF_RS2 SHALL be forced to 0.
REQ-030 Reset asserted mid-clear SHALL restart CNT at 0; reset in READY SHALL re-enter CLEAR per REQ-025.
REQ-031 RF_READY SHALL be a registered output, and the FSM SHALL hold in READY until the next reset.

Reset
REQ-032 Output reset values: RF_READY=0 (1 if CLEAR_ON_RESET=0); RF_RS1 and RF_RS2 = 0 while RF_READY=0.
REQ-033 No register write SHALL occur on a reset edge.
REQ-034 Register contents before clear completion are undefined and SHALL never be observable on the outputs.

Verification
REQ-035 Reset sequence: RST=1 for 1 edge, then 0 -> RF_READY=0 for 31 edges, 1 after edge 32; all 32 addresses read 0x00000000.
REQ-036 Writeback select: with RF_WE=1, RF_WA=5, ALU_RESULT=0xDEADBEEF, sel=3, then sel=0 with PC_PLUS4=0x00000104 to RF_WA=6 -> x5 reads 0xDEADBEEF and x6 reads 0x00000104.
REQ-037 x0 protection: write 0xFFFFFFFF to RF_WA=0 -> RF_ADR1=0 reads 0x00000000, both before and during the write cycle.
REQ-038 Bypass: x7=0x11111111; in the same cycle write 0x22222222 to x7 with RF_ADR1=RF_ADR2=7 -> both outputs show 0x22222222 before the edge and after it.
REQ-039 Mid-clear reset: reassert RST at edge 10 of CLEAR -> RF_READY rises exactly 32 edges after that reset edge.
REQ-040 Write while not ready: RF_WE=1 to x3 with 0xA5A5A5A5 during CLEAR -> after RF_READY rises, x3 reads 0x00000000.
